spk_serial_rx: RTL and testbench

// - Receiver end of the serial inter-layer spike link: FC1 spikes go out one bit per cycle, 20 spikes then a constant-1 bias slot.
// - Collects the stream back into a parallel spike vector, checks frame length and bias slot, emits one-cycle vec_valid.
// - Used by parallel-input LIF layers and by the debug/score tap on the FC1->FC2 link.

---
 rtl/snn_link_pkg.sv | 13 +
 rtl/spk_lag_align.sv | 21 ++
 rtl/spk_serial_rx.sv | 122 ++++++++++++
 tb/tb_spk_serial_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_link_pkg.sv
// rtl/snn_link_pkg.sv - shared constants and types for the serial spike link
package snn_link_pkg;

  localparam int N_SPK_DEF  = 20;
  localparam int BIAS_SLOTS = 1;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  function automatic int slot_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spk_lag_align.sv
// rtl/spk_lag_align.sv - delays in_valid so it lines up with a lagging spike bit
module spk_lag_align #(
  parameter int DATA_LAG = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic v_d
);

  logic v_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= in_valid;
  end

  // The flop always exists; DATA_LAG=0 simply bypasses it.
  assign v_d = (DATA_LAG == 0) ? in_valid : v_q;

endmodule

// File: rtl/spk_serial_rx.sv
// rtl/spk_serial_rx.sv - deserialises N_SPK spike slots plus a bias slot into a parallel vector
module spk_serial_rx
  import snn_link_pkg::*;
#(
  parameter int N_SPK    = N_SPK_DEF,
  parameter int DATA_LAG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_spk,
  output logic [N_SPK-1:0] spk_vec,
  output logic             vec_valid,
  output logic             bias_err,
  output logic             len_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int            SW       = slot_w(N_SPK);
  localparam logic [SW-1:0] BIAS_IDX = SW'(N_SPK);

  logic v_d;
  logic sample;

  spk_lag_align #(.DATA_LAG(DATA_LAG)) u_align (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .v_d      (v_d)
  );

  assign sample = v_d & in_spk;

  rx_state_t        state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [N_SPK-1:0] asm_q, asm_d;
  logic [N_SPK-1:0] spk_vec_d;
  logic             vec_valid_d, bias_err_d, len_err_d;
  logic [CNT_W-1:0] frame_cnt_d, err_cnt_d;
  logic             err_inc;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    asm_d       = asm_q;
    spk_vec_d   = spk_vec;
    vec_valid_d = 1'b0;
    bias_err_d  = 1'b0;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt;
    err_inc     = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (v_d) begin
          // Fresh frame: clear assembly so an aborted frame can never leak bits.
          asm_d    = '0;
          asm_d[0] = sample;
          slot_d   = SW'(1);
          state_d  = RX_RECV;
        end
      end
      RX_RECV: begin
        if (!v_d) begin
          len_err_d = 1'b1;
          err_inc   = 1'b1;
          asm_d     = '0;
          slot_d    = '0;
          state_d   = RX_IDLE;
        end else if (slot_q == BIAS_IDX) begin
          if (sample) begin
            spk_vec_d   = asm_q;
            vec_valid_d = 1'b1;
            frame_cnt_d = frame_cnt + CNT_W'(1);
          end else begin
            bias_err_d = 1'b1;
            err_inc    = 1'b1;
          end
          slot_d  = '0;
          state_d = RX_IDLE;
        end else begin
          for (int k = 0; k < N_SPK; k++) begin
            if (slot_q == SW'(k)) asm_d[k] = sample;
          end
          slot_d = slot_q + SW'(1);
        end
      end
    endcase

    err_cnt_d = (err_inc && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      slot_q    <= '0;
      asm_q     <= '0;
      spk_vec   <= '0;
      vec_valid <= 1'b0;
      bias_err  <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      asm_q     <= asm_d;
      spk_vec   <= spk_vec_d;
      vec_valid <= vec_valid_d;
      bias_err  <= bias_err_d;
      len_err   <= len_err_d;
      frame_cnt <= frame_cnt_d;
      err_cnt   <= err_cnt_d;
    end
  end

  assign busy = (state_q == RX_RECV);

endmodule

// File: tb/tb_spk_serial_rx.sv
// tb/tb_spk_serial_rx.sv - directed bench for spk_serial_rx with DATA_LAG=1
module tb_spk_serial_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_spk = 1'b0;
  logic [19:0] spk_vec, spk_vec2;
  logic        vec_valid, bias_err, len_err, busy;
  logic        vec_valid2, bias_err2, len_err2, busy2;
  logic [15:0] frame_cnt, err_cnt;
  logic [1:0]  frame_cnt2, err_cnt2;

  always #5 clk = ~clk;

  spk_serial_rx #(.N_SPK(20), .DATA_LAG(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_spk(in_spk),
    .spk_vec(spk_vec), .vec_valid(vec_valid), .bias_err(bias_err), .len_err(len_err),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  spk_serial_rx #(.N_SPK(20), .DATA_LAG(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_spk(in_spk),
    .spk_vec(spk_vec2), .vec_valid(vec_valid2), .bias_err(bias_err2), .len_err(len_err2),
    .busy(busy2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vv_cnt = 0, be_cnt = 0, le_cnt = 0;
  int chg_viol = 0, both_viol = 0;
  logic [19:0] vq[$];
  int          vcyc[$];
  logic [19:0] prev_vec = '0;
  logic        prev_bit = 1'b0;
  int exp_fc = 0, exp_ec = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vec_valid) begin
      vv_cnt = vv_cnt + 1;
      vq.push_back(spk_vec);
      vcyc.push_back(cyc);
    end
    if (bias_err) be_cnt = be_cnt + 1;
    if (len_err)  le_cnt = le_cnt + 1;
    if (bias_err && len_err) both_viol = both_viol + 1;
    if (!reset && (spk_vec !== prev_vec) && !vec_valid) chg_viol = chg_viol + 1;
    prev_vec = spk_vec;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    vv_cnt = 0; be_cnt = 0; le_cnt = 0;
    vq.delete(); vcyc.delete();
  endtask

  // in_spk carries the bit belonging to the previous cycle's in_valid.
  task automatic drive_cycle(input logic v, input logic b);
    in_valid = v;
    in_spk   = prev_bit;
    prev_bit = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic send_slots(input logic [19:0] pat, input logic bias, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, (i < 20) ? pat[i] : bias);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    exp_fc = 0; exp_ec = 0;
  endtask

  typedef struct {
    logic [19:0] pat;
    logic        bias;
    int          exp_vv;
    int          exp_be;
    logic [19:0] exp_vec;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{pat: 20'h80021, bias: 1'b1, exp_vv: 1, exp_be: 0, exp_vec: 20'h80021};
    tbl[1] = '{pat: 20'hFFFFF, bias: 1'b0, exp_vv: 0, exp_be: 1, exp_vec: 20'h80021};
    tbl[2] = '{pat: 20'h12345, bias: 1'b1, exp_vv: 1, exp_be: 0, exp_vec: 20'h12345};
    tbl[3] = '{pat: 20'h00000, bias: 1'b1, exp_vv: 1, exp_be: 0, exp_vec: 20'h00000};

    idle(3);
    check("rst_spk_vec", spk_vec, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;
    idle(2);

    for (int t = 0; t < 4; t++) begin
      clr_mon();
      send_slots(tbl[t].pat, tbl[t].bias, 21);
      idle(4);
      exp_fc += tbl[t].exp_vv;
      exp_ec += tbl[t].exp_be;
      check($sformatf("tbl%0d_vv", t), vv_cnt, tbl[t].exp_vv);
      check($sformatf("tbl%0d_be", t), be_cnt, tbl[t].exp_be);
      check($sformatf("tbl%0d_spk_vec", t), spk_vec, tbl[t].exp_vec);
      check($sformatf("tbl%0d_frame_cnt", t), frame_cnt, exp_fc);
      check($sformatf("tbl%0d_err_cnt", t), err_cnt, exp_ec);
    end

    // Short frame followed by a good all-ones frame
    clr_mon();
    send_slots(20'hFFFFF, 1'b1, 12);
    idle(4);
    exp_ec++;
    check("short_len_err", le_cnt, 1);
    check("short_vv", vv_cnt, 0);
    check("short_busy", busy, 0);
    send_slots(20'hFFFFF, 1'b1, 21);
    idle(4);
    exp_fc++;
    check("short_then_good_vv", vv_cnt, 1);
    check("short_then_good_vec", spk_vec, 20'hFFFFF);
    check("short_err_cnt", err_cnt, exp_ec);

    // Aborted ones frame, then a good zero frame
    clr_mon();
    send_slots(20'hFFFFF, 1'b1, 7);
    idle(3);
    send_slots(20'h00000, 1'b1, 21);
    idle(4);
    exp_ec++; exp_fc++;
    check("abort_len_err", le_cnt, 1);
    check("abort_vec", spk_vec, 20'h00000);

    // Back-to-back: three frames, 63 continuous valid cycles
    clr_mon();
    send_slots(20'h00001, 1'b1, 21);
    send_slots(20'hAAAAA, 1'b1, 21);
    send_slots(20'h55555, 1'b1, 21);
    idle(4);
    exp_fc += 3;
    check("b2b_vv", vv_cnt, 3);
    check("b2b_le", le_cnt, 0);
    if (vq.size() == 3 && vcyc.size() == 3) begin
      check("b2b_v0", vq[0], 20'h00001);
      check("b2b_v1", vq[1], 20'hAAAAA);
      check("b2b_v2", vq[2], 20'h55555);
      check("b2b_gap01", vcyc[1] - vcyc[0], 21);
      check("b2b_gap12", vcyc[2] - vcyc[1], 21);
    end
    check("b2b_frame_cnt", frame_cnt, exp_fc);

    // Reset at slot 10
    clr_mon();
    send_slots(20'hFFFFF, 1'b1, 11);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    idle(3);
    check("rst_mid_vv", vv_cnt + be_cnt + le_cnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_err_cnt", err_cnt, 0);
    check("rst_mid_spk_vec", spk_vec, 0);
    reset = 1'b0;
    idle(2);
    send_slots(20'h0F0F0, 1'b1, 21);
    idle(4);
    check("post_rst_vv", vv_cnt, 1);
    check("post_rst_vec", spk_vec, 20'h0F0F0);
    check("post_rst_frame_cnt", frame_cnt, 1);

    // Counter wrap / saturation on the CNT_W=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_slots(20'h00F00 ^ 20'(i), 1'b1, 21);
      idle(2);
      if (i == 3) check("c2_wrap_at4", frame_cnt2, 0);
    end
    check("c2_frame_cnt", frame_cnt2, 1);
    check("c16_frame_cnt", frame_cnt, 5);
    for (int i = 0; i < 4; i++) begin
      send_slots(20'h3C3C3, 1'b0, 21);
      idle(2);
      if (i == 2) check("c2_err_at3", err_cnt2, 3);
    end
    check("c2_err_sat", err_cnt2, 3);
    check("c16_err_cnt", err_cnt, 4);
    check("c2_vec_held", spk_vec2, 20'h00F00 ^ 20'd4);

    check("spk_vec_only_with_valid", chg_viol, 0);
    check("no_dual_err", both_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
